// File: rtl/pp_reduce_pipe.sv
// rtl/pp_reduce_pipe.sv - three-stage carry-save reduction of nine Booth partial products
// S1/S2 compress 9 -> 6 -> 2 vectors, S3 resolves with a carry-propagate add.
module pp_reduce_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] PP0,
  input  logic [WIDTH-1:0] PP1,
  input  logic [WIDTH-1:0] PP2,
  input  logic [WIDTH-1:0] PP3,
  input  logic [WIDTH-1:0] PP4,
  input  logic [WIDTH-1:0] PP5,
  input  logic [WIDTH-1:0] PP6,
  input  logic [WIDTH-1:0] PP7,
  input  logic [WIDTH-1:0] PP8,
  input  logic             in_neg_flag,
  input  logic             in_zero_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_product,
  output logic             out_neg_flag,
  output logic             out_zero_flag,
  output logic             busy
);

  // Returns {carry << 1, sum}; the carry shift drops the top bit (modulo 2^WIDTH).
  function automatic logic [2*WIDTH-1:0] csa(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] cy;
    s  = a ^ b ^ c;
    cy = ((a & b) | (a & c) | (b & c)) << 1;
    return {cy, s};
  endfunction

  logic                  stall;
  logic [5:0][WIDTH-1:0] s1_d, s1_q;
  logic                  s1_valid_q, s1_neg_q, s1_zero_q;
  logic [WIDTH-1:0]      a0, a1, a2, a3, b0, b1;
  logic [WIDTH-1:0]      s2_sum_d, s2_carry_d, s2_sum_q, s2_carry_q;
  logic                  s2_valid_q, s2_neg_q, s2_zero_q;
  logic [WIDTH-1:0]      out_product_d, out_product_q;
  logic                  out_valid_q, out_neg_q, out_zero_q;

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;

  always_comb begin
    s1_d = '0;
    {s1_d[1], s1_d[0]} = csa(PP0, PP1, PP2);
    {s1_d[3], s1_d[2]} = csa(PP3, PP4, PP5);
    {s1_d[5], s1_d[4]} = csa(PP6, PP7, PP8);
  end

  // 6 -> 4 -> 3 -> 2 reduction between the S1 and S2 registers.
  always_comb begin
    {a1, a0} = csa(s1_q[0], s1_q[1], s1_q[2]);
    {a3, a2} = csa(s1_q[3], s1_q[4], s1_q[5]);
    {b1, b0} = csa(a0, a1, a2);
    {s2_carry_d, s2_sum_d} = csa(b0, b1, a3);
  end

  assign out_product_d = s2_sum_q + s2_carry_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q          <= '0;
      s1_valid_q    <= 1'b0;
      s1_neg_q      <= 1'b0;
      s1_zero_q     <= 1'b0;
      s2_sum_q      <= '0;
      s2_carry_q    <= '0;
      s2_valid_q    <= 1'b0;
      s2_neg_q      <= 1'b0;
      s2_zero_q     <= 1'b0;
      out_product_q <= '0;
      out_valid_q   <= 1'b0;
      out_neg_q     <= 1'b0;
      out_zero_q    <= 1'b0;
    end else if (!stall) begin
      s1_q          <= s1_d;
      s1_valid_q    <= in_valid;
      s1_neg_q      <= in_neg_flag;
      s1_zero_q     <= in_zero_flag;
      s2_sum_q      <= s2_sum_d;
      s2_carry_q    <= s2_carry_d;
      s2_valid_q    <= s1_valid_q;
      s2_neg_q      <= s1_neg_q;
      s2_zero_q     <= s1_zero_q;
      out_product_q <= out_product_d;
      out_valid_q   <= s2_valid_q;
      out_neg_q     <= s2_neg_q;
      out_zero_q    <= s2_zero_q | (out_product_d == '0);
    end
  end

  assign out_valid     = out_valid_q;
  assign out_product   = out_product_q;
  assign out_neg_flag  = out_neg_q;
  assign out_zero_flag = out_zero_q;
  assign busy          = s1_valid_q | s2_valid_q | out_valid_q;

endmodule

// File: tb/tb_pp_reduce_pipe.sv
// tb/tb_pp_reduce_pipe.sv - directed and Booth-driven checks for pp_reduce_pipe
module tb_pp_reduce_pipe;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_neg, in_zero;
  logic         out_valid, out_ready, out_neg, out_zero, busy;
  logic [W-1:0] pp [9];
  logic [W-1:0] out_product;
  int           total = 0;
  int           bad = 0;
  logic [W+1:0] got [$];
  logic [W+1:0] exp_q [$];

  always #5 clk = ~clk;

  pp_reduce_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .PP0(pp[0]), .PP1(pp[1]), .PP2(pp[2]), .PP3(pp[3]), .PP4(pp[4]),
    .PP5(pp[5]), .PP6(pp[6]), .PP7(pp[7]), .PP8(pp[8]),
    .in_neg_flag(in_neg), .in_zero_flag(in_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .out_neg_flag(out_neg), .out_zero_flag(out_zero), .busy(busy)
  );

  always @(negedge clk)
    if (!rst && out_valid && out_ready) got.push_back({out_zero, out_neg, out_product});

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, expv);
    end
  endtask

  task automatic clr_pp();
    for (int i = 0; i < 9; i++) pp[i] = '0;
  endtask

  // Radix-4 Booth generator model for 16-bit A/B; nine digits cover unsigned B too.
  task automatic booth(input logic [15:0] a, input logic [15:0] b, input logic sgn);
    logic [31:0] ax;
    logic [17:0] bx;
    logic [2:0]  t;
    logic [31:0] m;
    ax = sgn ? {{16{a[15]}}, a} : {16'b0, a};
    bx = sgn ? {{2{b[15]}}, b} : {2'b0, b};
    for (int i = 0; i < 9; i++) begin
      t[2] = bx[2*i+1];
      t[1] = bx[2*i];
      if (i == 0) t[0] = 1'b0;
      else        t[0] = bx[2*i-1];
      case (t)
        3'b001, 3'b010: m = ax;
        3'b011:         m = ax << 1;
        3'b100:         m = -(ax << 1);
        3'b101, 3'b110: m = -ax;
        default:        m = '0;
      endcase
      pp[i] = m << (2*i);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b, input logic sgn);
    logic [31:0] ax, bx;
    ax = sgn ? {{16{a[15]}}, a} : {16'b0, a};
    bx = sgn ? {{16{b[15]}}, b} : {16'b0, b};
    return ax * bx;
  endfunction

  // Drives the current pp[] for one cycle, then watches five edges.
  task automatic run_one(input string tag, input logic n, input logic z,
                         input logic [W-1:0] ep, input logic en, input logic ez);
    int first = 0;
    int cnt = 0;
    logic [W-1:0] p = '0;
    logic nf = 1'b0, zf = 1'b0;
    in_neg = n; in_zero = z; in_valid = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (out_valid) begin
        cnt++;
        if (first == 0) begin
          first = c; p = out_product; nf = out_neg; zf = out_zero;
        end
      end
    end
    chk({tag, " latency"}, first, 3);
    chk({tag, " valid_cycles"}, cnt, 1);
    chk({tag, " product"}, p, ep);
    chk({tag, " neg"}, nf, en);
    chk({tag, " zero"}, zf, ez);
  endtask

  initial begin
    int sent;
    int n_ok;
    logic acc, hold, stale;
    logic [15:0] ra, rb;
    logic rs, rn, rz;
    logic [31:0] prod;

    rst = 1'b1; in_valid = 1'b0; in_neg = 1'b0; in_zero = 1'b0; out_ready = 1'b0;
    clr_pp();
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst out_product", out_product, 0);
    chk("rst flags", {out_neg, out_zero}, 0);
    #11 rst = 1'b0;
    @(posedge clk); #1;
    chk("empty ignores out_ready", in_ready, 1);
    out_ready = 1'b1;

    clr_pp(); pp[0] = 32'h3; pp[1] = 32'h5;
    run_one("add3_5", 1'b0, 1'b0, 32'h8, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) pp[i] = 32'hFFFF_FFFF;
    run_one("all_ones", 1'b1, 1'b0, 32'hFFFF_FFF7, 1'b1, 1'b0);
    clr_pp(); pp[0] = 32'h8000_0000; pp[1] = 32'h8000_0000;
    run_one("wrap", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    clr_pp(); pp[4] = 32'h1234_0000;
    run_one("zero_sideband", 1'b0, 1'b1, 32'h1234_0000, 1'b0, 1'b1);
    booth(16'h0007, 16'hFFFD, 1'b1);
    run_one("booth_7x-3", 1'b1, 1'b0, 32'hFFFF_FFEB, 1'b1, 1'b0);

    // Stream of six with a two-cycle consumer stall.
    clr_pp(); in_neg = 1'b0; in_zero = 1'b0;
    got.delete(); sent = 0;
    for (int c = 0; c < 40 && got.size() < 6; c++) begin
      out_ready = !(c == 4 || c == 5);
      in_valid  = (sent < 6);
      pp[0]     = sent + 1;
      #1;
      if (c == 4 || c == 5) chk("stall in_ready", in_ready, 0);
      if (c == 6) chk("resume in_ready", in_ready, 1);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("stream count", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) chk("stream order", got[i][W-1:0], i + 1);

    // Random Booth products with random back-pressure.
    got.delete(); exp_q.delete(); sent = 0; hold = 1'b0;
    for (int c = 0; c < 6000 && !(sent == 1000 && got.size() == 1000); c++) begin
      out_ready = ($urandom_range(0, 3) != 0) || (sent == 1000);
      if (!hold && sent < 1000) begin
        ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
        rn = 1'($urandom); rz = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 15) == 0) ra = 16'h0;
        booth(ra, rb, rs);
        in_neg = rn; in_zero = rz;
        prod = ref_mul(ra, rb, rs);
        hold = 1'b1;
      end
      in_valid = hold;
      #1;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        exp_q.push_back({rz | (prod == 32'h0), rn, prod});
        hold = 1'b0;
        sent++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("random count", got.size(), 1000);
    n_ok = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n_ok; i++) chk("random result", got[i], exp_q[i]);

    // Asynchronous reset with three entries in flight.
    clr_pp(); out_ready = 1'b1; in_neg = 1'b0; in_zero = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pp[0] = 32'h10 + k; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre-reset out_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async rst out_valid", out_valid, 0);
    chk("async rst busy", busy, 0);
    chk("async rst in_ready", in_ready, 1);
    chk("async rst product", out_product, 0);
    got.delete();
    #2 rst = 1'b0;
    stale = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid || busy) stale = 1'b1;
    end
    chk("no stale after reset", {stale, 32'(got.size())}, 0);
    pp[0] = 32'h55;
    run_one("post_reset", 1'b0, 1'b0, 32'h55, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
